// File: rtl/bus_move_ctrl.sv
// Command sequencer owning registers r0/r1 around a two-source/two-destination bus stage.
// Runs MOVE/LOAD/SWAP/CLEAR, drives the bus selects and captures bus results after a settle time.
module bus_move_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_src,
  input  logic             cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             bus_from,
  output logic             bus_to,
  output logic [WIDTH-1:0] bus_in0,
  output logic [WIDTH-1:0] bus_in1,
  input  logic [WIDTH-1:0] bus_out0,
  input  logic [WIDTH-1:0] bus_out1,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StDrive, StLatch, StSwapFin, StDone} state_e;

  localparam logic [1:0] OpMove  = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpSwap  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  state_e           state_q;
  logic [WIDTH-1:0] r0_q, r1_q, tmp_q;
  logic [3:0]       cnt_q;
  logic [1:0]       op_q;
  logic             dst_q;
  logic             phase_q;
  logic             from_q, to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r0_q    <= '0;
      r1_q    <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OpMove;
      dst_q   <= 1'b0;
      phase_q <= 1'b0;
      from_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          from_q <= 1'b0;
          to_q   <= 1'b0;
          if (cmd_valid) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            phase_q <= 1'b0;
            case (cmd_op)
              OpLoad: begin
                if (cmd_dst) r1_q <= cmd_imm;
                else         r0_q <= cmd_imm;
                state_q <= StDone;
              end
              OpClear: begin
                if (cmd_dst) r1_q <= '0;
                else         r0_q <= '0;
                state_q <= StDone;
              end
              OpMove: begin
                // Destination 0 is reached through out0 (bus_to = 1), destination 1 through out1.
                from_q  <= cmd_src;
                to_q    <= ~cmd_dst;
                cnt_q   <= SettleInit;
                state_q <= StDrive;
              end
              default: begin
                // SWAP phase A routes r0 to out0 for parking in tmp.
                from_q  <= 1'b0;
                to_q    <= 1'b1;
                cnt_q   <= SettleInit;
                state_q <= StDrive;
              end
            endcase
          end
        end
        StDrive: begin
          if (cnt_q <= 4'd1) state_q <= StLatch;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StLatch: begin
          if (op_q == OpSwap) begin
            if (!phase_q) begin
              tmp_q   <= bus_out0;
              phase_q <= 1'b1;
              from_q  <= 1'b1;
              to_q    <= 1'b1;
              cnt_q   <= SettleInit;
              state_q <= StDrive;
            end else begin
              r0_q    <= bus_out0;
              from_q  <= 1'b0;
              to_q    <= 1'b0;
              state_q <= StSwapFin;
            end
          end else begin
            if (dst_q) r1_q <= bus_out1;
            else       r0_q <= bus_out0;
            from_q  <= 1'b0;
            to_q    <= 1'b0;
            state_q <= StDone;
          end
        end
        StSwapFin: begin
          r1_q    <= tmp_q;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign bus_from  = from_q;
  assign bus_to    = to_q;
  assign bus_in0   = r0_q;
  assign bus_in1   = r1_q;
  assign reg0      = r0_q;
  assign reg1      = r1_q;

endmodule
